// File: rtl/fp_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// fp_addsub_ctrl
//   Multi-cycle sequencer for single-precision floating-point add/subtract.
//   One shared 25-bit adder and one shared two's-complement unit are
//   time-multiplexed across exponent compare, alignment, mantissa
//   add/subtract and normalisation. Rounding is truncation; denormal
//   operands and results are flushed to zero.
//
//   Ports
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     start  : request pulse, sampled only in IDLE
//     op     : 0 = in1+in2, 1 = in1-in2 (captured with start)
//     in1    : IEEE754 operand A (captured with start)
//     in2    : IEEE754 operand B (captured with start)
//     result : IEEE754 result, held from done until a later result
//     busy   : high from the cycle after start is accepted through done
//     done   : one-cycle pulse, result and flags valid
//     ovf    : result overflowed to +/-inf
//     unf    : result flushed to +/-0 by underflow
//     nan    : result is the canonical quiet NaN
// ---------------------------------------------------------------------------
module fp_addsub_ctrl #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    op,
  input  logic [EXP_W+MANT_W-1:0] in1,
  input  logic [EXP_W+MANT_W-1:0] in2,
  output logic [EXP_W+MANT_W-1:0] result,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf,
  output logic                    unf,
  output logic                    nan
);

  localparam int FP_W = EXP_W + MANT_W;
  localparam int FW   = MANT_W - 1;
  localparam int AW   = MANT_W + 1;

  localparam logic [EXP_W-1:0] EXP_MAX   = '1;
  localparam logic [AW-1:0]    ONE_A     = AW'(1);
  localparam logic [AW-1:0]    SHIFT_LIM = AW'(MANT_W);
  localparam logic [FP_W-1:0]  QNAN      = {1'b0, EXP_MAX, 1'b1, {(FW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_EXP, S_ALIGN, S_ADD, S_NORM, S_DONE
  } state_t;

  state_t r_state, w_next;

  // Captured request
  logic [FP_W-1:0]  r_a, r_b;
  logic             r_op;

  // Working datapath state
  logic             r_sl, r_ss;        // signs of larger / smaller operand
  logic [MANT_W-1:0] r_ml, r_ms;       // mantissas with hidden bit
  logic             r_sub;             // effective subtract
  logic             r_borrow;          // eA < eB, operands were swapped
  logic [AW-1:0]    r_ediff;           // raw eA - eB from the adder
  logic [EXP_W-1:0] r_exp;
  logic [AW-1:0]    r_mant;
  logic             r_sign;

  // Result registers
  logic [FP_W-1:0]  r_result;
  logic             r_ovf, r_unf, r_nan;

  // Field decode of the captured operands (B sign is the effective sign)
  logic             w_sa, w_sb;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [FW-1:0]    w_fa, w_fb;

  assign w_sa = r_a[FP_W-1];
  assign w_ea = r_a[FP_W-2 -: EXP_W];
  assign w_fa = r_a[FW-1:0];
  assign w_sb = r_b[FP_W-1] ^ r_op;
  assign w_eb = r_b[FP_W-2 -: EXP_W];
  assign w_fb = r_b[FW-1:0];

  // Shared arithmetic units
  logic [AW-1:0] w_cmp_in, w_cmp_out;
  logic [AW-1:0] w_add_a, w_add_b, w_add_sum;

  assign w_cmp_out = ~w_cmp_in + ONE_A;
  assign w_add_sum = w_add_a + w_add_b;

  function automatic logic [AW-1:0] f_neg(input logic [AW-1:0] x);
    return ~x + ONE_A;
  endfunction

  // Complement unit input: eB in EXP, raw difference in ALIGN, mS in ADD
  always_comb begin
    w_cmp_in = '0;
    case (r_state)
      S_EXP:   w_cmp_in = AW'(w_eb);
      S_ALIGN: w_cmp_in = r_ediff;
      S_ADD:   w_cmp_in = {1'b0, r_ms};
      default: w_cmp_in = '0;
    endcase
  end

  // Adder inputs: eA - eB in EXP, mL +/- mS in ADD
  always_comb begin
    w_add_a = '0;
    w_add_b = '0;
    case (r_state)
      S_EXP: begin
        w_add_a = AW'(w_ea);
        w_add_b = w_cmp_out;
      end
      S_ADD: begin
        w_add_a = {1'b0, r_ml};
        w_add_b = r_sub ? w_cmp_out : {1'b0, r_ms};
      end
      default: ;
    endcase
  end

  // Special operand resolution (only acted on in EXP)
  logic            w_special, w_spec_nan;
  logic [FP_W-1:0] w_spec_res;
  logic            w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;

  assign w_nan_a  = (w_ea == EXP_MAX) && (w_fa != '0);
  assign w_nan_b  = (w_eb == EXP_MAX) && (w_fb != '0);
  assign w_inf_a  = (w_ea == EXP_MAX) && (w_fa == '0);
  assign w_inf_b  = (w_eb == EXP_MAX) && (w_fb == '0);
  assign w_zero_a = (w_ea == '0);
  assign w_zero_b = (w_eb == '0);

  always_comb begin
    w_special  = 1'b1;
    w_spec_nan = 1'b0;
    w_spec_res = '0;
    if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sa != w_sb))) begin
      w_spec_res = QNAN;
      w_spec_nan = 1'b1;
    end else if (w_inf_a) begin
      w_spec_res = {w_sa, EXP_MAX, {FW{1'b0}}};
    end else if (w_inf_b) begin
      w_spec_res = {w_sb, EXP_MAX, {FW{1'b0}}};
    end else if (w_zero_a && w_zero_b) begin
      // Only (-0)+(-0) keeps the negative sign
      w_spec_res = {w_sa & w_sb, {(FP_W-1){1'b0}}};
    end else if (w_zero_a) begin
      w_spec_res = {w_sb, w_eb, w_fb};
    end else if (w_zero_b) begin
      w_spec_res = {w_sa, w_ea, w_fa};
    end else begin
      w_special = 1'b0;
    end
  end

  // Alignment: the complement unit turns a borrowed difference into |eA-eB|
  logic [AW-1:0]     w_diff;
  logic [MANT_W-1:0] w_ms_al;

  assign w_diff  = r_borrow ? w_cmp_out : r_ediff;
  assign w_ms_al = (w_diff >= SHIFT_LIM) ? '0 : (r_ms >> w_diff);

  // Mantissa add: a negative difference only arises with equal exponents
  logic          w_sum_neg;
  logic [AW-1:0] w_add_mant;

  assign w_sum_neg  = r_sub & w_add_sum[AW-1];
  assign w_add_mant = w_sum_neg ? f_neg(w_add_sum) : w_add_sum;

  // Normalisation step
  logic             w_norm_done, w_norm_ovf, w_norm_unf;
  logic [FP_W-1:0]  w_norm_res;
  logic [AW-1:0]    w_norm_mant;
  logic [EXP_W-1:0] w_norm_exp, w_exp_inc, w_exp_dec;

  assign w_exp_inc = r_exp + 1'b1;
  assign w_exp_dec = r_exp - 1'b1;

  always_comb begin
    w_norm_done = 1'b0;
    w_norm_ovf  = 1'b0;
    w_norm_unf  = 1'b0;
    w_norm_res  = '0;
    w_norm_mant = r_mant;
    w_norm_exp  = r_exp;
    if (r_mant[AW-1]) begin
      w_norm_done = 1'b1;
      if (w_exp_inc == EXP_MAX) begin
        w_norm_res = {r_sign, EXP_MAX, {FW{1'b0}}};
        w_norm_ovf = 1'b1;
      end else begin
        w_norm_res = {r_sign, w_exp_inc, r_mant[FW:1]};
      end
    end else if (r_mant[AW-2]) begin
      w_norm_done = 1'b1;
      w_norm_res  = {r_sign, r_exp, r_mant[FW-1:0]};
    end else if (r_mant == '0) begin
      w_norm_done = 1'b1;
    end else begin
      w_norm_mant = r_mant << 1;
      w_norm_exp  = w_exp_dec;
      if (w_exp_dec == '0) begin
        w_norm_done = 1'b1;
        w_norm_res  = {r_sign, {(FP_W-1){1'b0}}};
        w_norm_unf  = 1'b1;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_EXP;
      S_EXP:   w_next = w_special ? S_DONE : S_ALIGN;
      S_ALIGN: w_next = S_ADD;
      S_ADD:   w_next = S_NORM;
      S_NORM:  if (w_norm_done) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  assign result = r_result;
  assign ovf    = r_ovf;
  assign unf    = r_unf;
  assign nan    = r_nan;

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 1'b0;
      r_sl     <= 1'b0;
      r_ss     <= 1'b0;
      r_ml     <= '0;
      r_ms     <= '0;
      r_sub    <= 1'b0;
      r_borrow <= 1'b0;
      r_ediff  <= '0;
      r_exp    <= '0;
      r_mant   <= '0;
      r_sign   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_nan    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a  <= in1;
            r_b  <= in2;
            r_op <= op;
          end
        end
        S_EXP: begin
          if (w_special) begin
            r_result <= w_spec_res;
            r_nan    <= w_spec_nan;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
          end else begin
            r_borrow <= w_add_sum[AW-1];
            r_ediff  <= w_add_sum;
            r_sub    <= w_sa ^ w_sb;
            if (w_add_sum[AW-1]) begin
              r_ml  <= {1'b1, w_fb};
              r_ms  <= {1'b1, w_fa};
              r_sl  <= w_sb;
              r_ss  <= w_sa;
              r_exp <= w_eb;
            end else begin
              r_ml  <= {1'b1, w_fa};
              r_ms  <= {1'b1, w_fb};
              r_sl  <= w_sa;
              r_ss  <= w_sb;
              r_exp <= w_ea;
            end
          end
        end
        S_ALIGN: r_ms <= w_ms_al;
        S_ADD: begin
          r_mant <= w_add_mant;
          r_sign <= w_sum_neg ? r_ss : r_sl;
        end
        S_NORM: begin
          r_mant <= w_norm_mant;
          r_exp  <= w_norm_exp;
          if (w_norm_done) begin
            r_result <= w_norm_res;
            r_ovf    <= w_norm_ovf;
            r_unf    <= w_norm_unf;
            r_nan    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fp_addsub_ctrl
//   Directed vectors with hand-computed expectations. The driver pushes the
//   expected response into a scoreboard queue when a request is accepted; a
//   monitor pops and compares whenever done is presented.
// ---------------------------------------------------------------------------
module tb_fp_addsub_ctrl;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        op    = 1'b0;
  logic [31:0] in1   = '0;
  logic [31:0] in2   = '0;
  logic [31:0] result;
  logic        busy, done, ovf, unf, nan;

  fp_addsub_ctrl #(.MANT_W(24), .EXP_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .in1    (in1),
    .in2    (in2),
    .result (result),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .unf    (unf),
    .nan    (nan)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        nan;
    int          lat;   // negative: latency not checked
    int          t0;
    int          id;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   opid   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 result=%h, required no done", result);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("op%0d_result", e.id), result, e.res);
        chk($sformatf("op%0d_ovf", e.id), 32'(ovf), 32'(e.ovf));
        chk($sformatf("op%0d_unf", e.id), 32'(unf), 32'(e.unf));
        chk($sformatf("op%0d_nan", e.id), 32'(nan), 32'(e.nan));
        if (e.lat >= 0)
          chk($sformatf("op%0d_latency", e.id), 32'(cyc - e.t0 + 1), 32'(e.lat));
      end
    end
  end

  // mode 0: plain; 1: extra start while busy; 2: extra start during done
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic o,
                       input logic [31:0] er, input logic eo, input logic eu,
                       input logic en, input int el, input int mode);
    exp_t e;
    int   k;
    @(negedge clk);
    in1   = a;
    in2   = b;
    op    = o;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.res = er; e.ovf = eo; e.unf = eu; e.nan = en;
    e.lat = el; e.t0 = cyc; e.id = opid;
    sbq.push_back(e);
    if (mode == 1) begin
      @(negedge clk);
      in1 = 32'h40400000; in2 = 32'h40400000; op = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    if (mode == 2) begin
      k = 0;
      while (!done && k < 100) begin
        @(negedge clk);
        k++;
      end
      if (k >= 100) begin
        n_chk++; n_fail++;
        $display("FAIL op%0d_done_timeout: got no done, required done within 100 cycles", opid);
      end
      in1 = 32'h40400000; in2 = 32'h40400000; op = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk($sformatf("op%0d_start_in_done_ignored_busy", opid), 32'(busy), 32'd0);
    end
    k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL op%0d_busy_timeout: got busy=1, required idle within 200 cycles", opid);
    end
    @(negedge clk);
    chk($sformatf("op%0d_result_held", opid), result, er);
    opid++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_result", result, 32'h0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_unf", 32'(unf), 32'd0);
    chk("reset_nan", 32'(nan), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    //     in1           in2           op    result        ovf   unf   nan  lat mode
    do_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, 5, 1);
    do_op(32'h3FC00000, 32'hBE800000, 1'b0, 32'h3FA00000, 1'b0, 1'b0, 1'b0, 5, 0);
    do_op(32'h3F800000, 32'h3F800001, 1'b1, 32'hB4000000, 1'b0, 1'b0, 1'b0, 28, 0);
    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b0, 5, 0);
    do_op(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 5, 0);
    do_op(32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0, -1, 0);
    do_op(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0, 2, 0);
    do_op(32'h00000000, 32'h80000000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 2, 0);
    do_op(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 5, 0);
    do_op(32'h3E800000, 32'h3FC00000, 1'b0, 32'h3FE00000, 1'b0, 1'b0, 1'b0, 5, 0);
    do_op(32'h3F800000, 32'h33000000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0, 5, 0);
    do_op(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 1'b0, 1'b0, 2, 0);
    do_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, 5, 2);
    do_op(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0, 1'b1, 2, 0);

    // Abort an operation with reset in its third cycle
    @(negedge clk);
    in1 = 32'h3F800000; in2 = 32'h3F800000; op = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    in1 = 32'h40400000; in2 = 32'h40400000; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_result", result, 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_nan", 32'(nan), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    chk("abort_unf", 32'(unf), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    do_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, 5, 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
